// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: FSM states,
// instruction classes, opcode/funct constants, ALUOp codes, the EXTOp/NPCOp/
// WDSel/DMType encodings, trap causes, and two small decode helpers.
package mc_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,   // R, I-ALU, lui, auipc
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5
    } instr_class_e;

    // Opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;   // sub / sra / srai

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;

    // ALUOp codes
    localparam logic [4:0] ALU_NOP   = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd1;
    localparam logic [4:0] ALU_SUB   = 5'd2;
    localparam logic [4:0] ALU_SLL   = 5'd3;
    localparam logic [4:0] ALU_SLT   = 5'd4;
    localparam logic [4:0] ALU_SLTU  = 5'd5;
    localparam logic [4:0] ALU_XOR   = 5'd6;
    localparam logic [4:0] ALU_SRL   = 5'd7;
    localparam logic [4:0] ALU_SRA   = 5'd8;
    localparam logic [4:0] ALU_OR    = 5'd9;
    localparam logic [4:0] ALU_AND   = 5'd10;
    localparam logic [4:0] ALU_LUI   = 5'd11;
    localparam logic [4:0] ALU_AUIPC = 5'd12;

    // EXTOp one-hot: ISHAMT,I,S,B,U,J (bit5..0)
    localparam logic [5:0] EXT_NONE   = 6'b000000;
    localparam logic [5:0] EXT_ISHAMT = 6'b100000;
    localparam logic [5:0] EXT_I      = 6'b010000;
    localparam logic [5:0] EXT_S      = 6'b001000;
    localparam logic [5:0] EXT_B      = 6'b000100;
    localparam logic [5:0] EXT_U      = 6'b000010;
    localparam logic [5:0] EXT_J      = 6'b000001;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JAL    = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    localparam logic [2:0] DM_NONE = 3'b000;
    localparam logic [2:0] DM_W    = 3'b100;
    localparam logic [2:0] DM_H    = 3'b010;
    localparam logic [2:0] DM_B    = 3'b001;
    localparam logic [2:0] DM_HU   = 3'b110;
    localparam logic [2:0] DM_BU   = 3'b101;

    localparam logic CAUSE_ILLEGAL = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    // Funct3 -> ALU op shared by R-type and I-ALU (alternate forms patched by caller).
    function automatic logic [4:0] alu_base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // beq/bge/bgeu take on Zero, bne/blt/bltu on !Zero. For blt/bge the ALU
    // computes SLT(U), whose result is zero exactly when the "ge" side holds.
    function automatic logic branch_taken(input logic [2:0] f3, input logic zero);
        return zero ^ (f3[2] ^ f3[0]);
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational RV32I decoder.
// Ports: op/funct7/funct3 (from IR) in; cls (instruction class), alu_op,
// ext_op, alu_src, wd_sel, dm_type and illegal out.
module mc_ctrl_fsm_decode
    import mc_ctrl_fsm_pkg::*;
(
    input  logic [6:0]   op,
    input  logic [6:0]   funct7,
    input  logic [2:0]   funct3,
    output instr_class_e cls,
    output logic [4:0]   alu_op,
    output logic [5:0]   ext_op,
    output logic         alu_src,
    output logic [1:0]   wd_sel,
    output logic [2:0]   dm_type,
    output logic         illegal
);

    always_comb begin
        cls     = CLS_ALU;
        alu_op  = ALU_NOP;
        ext_op  = EXT_NONE;
        alu_src = 1'b0;
        wd_sel  = WD_ALU;
        dm_type = DM_NONE;
        illegal = 1'b0;
        case (op)
            OP_R: begin
                alu_op = alu_base_op(funct3);
                if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD_SUB)  alu_op  = ALU_SUB;
                    else if (funct3 == F3_SR)  alu_op  = ALU_SRA;
                    else                       illegal = 1'b1;
                end else if (funct7 != F7_ZERO) begin
                    illegal = 1'b1;
                end
            end
            OP_IMM: begin
                alu_op  = alu_base_op(funct3);
                alu_src = 1'b1;
                ext_op  = EXT_I;
                // Shift-immediates reuse funct7 as the shamt-type field.
                if (funct3 == F3_SLL) begin
                    ext_op  = EXT_ISHAMT;
                    illegal = (funct7 != F7_ZERO);
                end else if (funct3 == F3_SR) begin
                    ext_op = EXT_ISHAMT;
                    if (funct7 == F7_ALT)        alu_op  = ALU_SRA;
                    else if (funct7 != F7_ZERO)  illegal = 1'b1;
                end
            end
            OP_LOAD: begin
                cls     = CLS_LOAD;
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                ext_op  = EXT_I;
                wd_sel  = WD_MEM;
                case (funct3)
                    3'b000:  dm_type = DM_B;
                    3'b001:  dm_type = DM_H;
                    3'b010:  dm_type = DM_W;
                    3'b100:  dm_type = DM_BU;
                    3'b101:  dm_type = DM_HU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_STORE: begin
                cls     = CLS_STORE;
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                ext_op  = EXT_S;
                case (funct3)
                    3'b000:  dm_type = DM_B;
                    3'b001:  dm_type = DM_H;
                    3'b010:  dm_type = DM_W;
                    default: illegal = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                cls    = CLS_BRANCH;
                ext_op = EXT_B;
                case (funct3)
                    3'b000, 3'b001: alu_op  = ALU_SUB;
                    3'b100, 3'b101: alu_op  = ALU_SLT;
                    3'b110, 3'b111: alu_op  = ALU_SLTU;
                    default:        illegal = 1'b1;
                endcase
            end
            OP_JAL: begin
                cls    = CLS_JAL;
                alu_op = ALU_ADD;
                ext_op = EXT_J;
                wd_sel = WD_PC4;
            end
            OP_JALR: begin
                cls     = CLS_JALR;
                alu_op  = ALU_ADD;
                alu_src = 1'b1;
                ext_op  = EXT_I;
                wd_sel  = WD_PC4;
                illegal = (funct3 != 3'b000);
            end
            OP_LUI: begin
                alu_op  = ALU_LUI;
                alu_src = 1'b1;
                ext_op  = EXT_U;
            end
            OP_AUIPC: begin
                alu_op  = ALU_AUIPC;
                alu_src = 1'b1;
                ext_op  = EXT_U;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB over a
// req/ack memory port, traps on illegal encodings and memory timeouts.
// Ports: clk, rst (sync, active-high); Op/Funct7/Funct3 from the latched IR,
// Zero from the ALU, mem_ack from memory. Outputs: mem_req/MemWrite, the
// IRWrite/PCWrite/RegWrite strobes, datapath selects ALUSrc/EXTOp/ALUOp/
// NPCOp/WDSel/DMType, and trap/trap_cause.
module mc_ctrl_fsm
    import mc_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit TRAP_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] Op,
    input  logic [6:0] Funct7,
    input  logic [2:0] Funct3,
    input  logic       Zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       ALUSrc,
    output logic [5:0] EXTOp,
    output logic [4:0] ALUOp,
    output logic [2:0] NPCOp,
    output logic [1:0] WDSel,
    output logic [2:0] DMType,
    output logic       trap,
    output logic       trap_cause
);

    localparam int               CNT_W     = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state, state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             cause_q, cause_nxt;

    instr_class_e cls;
    logic [4:0]   dec_alu_op;
    logic [5:0]   dec_ext_op;
    logic         dec_alu_src;
    logic [1:0]   dec_wd_sel;
    logic [2:0]   dec_dm_type;
    logic         dec_illegal;

    logic req_phase, mem_stall, timeout;

    mc_ctrl_fsm_decode u_decode (
        .op      (Op),
        .funct7  (Funct7),
        .funct3  (Funct3),
        .cls     (cls),
        .alu_op  (dec_alu_op),
        .ext_op  (dec_ext_op),
        .alu_src (dec_alu_src),
        .wd_sel  (dec_wd_sel),
        .dm_type (dec_dm_type),
        .illegal (dec_illegal)
    );

    assign req_phase = (state == S_FETCH) || (state == S_MEM);
    assign mem_stall = req_phase && !mem_ack;
    // Counter holds the number of wait cycles already spent; this stall would be the last allowed.
    assign timeout   = mem_stall && (wait_cnt == WAIT_LAST);

    // State register, wait counter, trap cause
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            cause_q  <= CAUSE_ILLEGAL;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (mem_stall)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        case (state)
            S_FETCH: begin
                if (mem_ack) begin
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cls == CLS_BRANCH)
                    state_nxt = S_FETCH;
                else if (cls == CLS_LOAD || cls == CLS_STORE)
                    state_nxt = S_MEM;
                else
                    state_nxt = S_WB;
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_nxt = (cls == CLS_STORE) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_WB:    state_nxt = S_FETCH;
            S_TRAP:  if (!TRAP_STICKY) state_nxt = S_FETCH;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs; everything is held at 0 while rst is asserted so a reset
    // mid-instruction can never leak a partial write.
    always_comb begin
        mem_req    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        ALUSrc     = 1'b0;
        EXTOp      = EXT_NONE;
        ALUOp      = ALU_NOP;
        NPCOp      = NPC_PLUS4;
        WDSel      = WD_ALU;
        DMType     = DM_NONE;
        trap       = 1'b0;
        trap_cause = 1'b0;
        if (!rst) begin
            if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
                ALUSrc = dec_alu_src;
                EXTOp  = dec_ext_op;
                ALUOp  = dec_alu_op;
                WDSel  = dec_wd_sel;
                DMType = dec_dm_type;
            end
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    IRWrite = mem_ack;
                end
                S_EXEC: begin
                    if (cls == CLS_BRANCH) begin
                        PCWrite = 1'b1;
                        NPCOp   = branch_taken(Funct3, Zero) ? NPC_BRANCH : NPC_PLUS4;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    MemWrite = (cls == CLS_STORE);
                    PCWrite  = (cls == CLS_STORE) && mem_ack;
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    PCWrite  = 1'b1;
                    if (cls == CLS_JAL)       NPCOp = NPC_JAL;
                    else if (cls == CLS_JALR) NPCOp = NPC_JALR;
                end
                S_TRAP: begin
                    trap       = 1'b1;
                    trap_cause = cause_q;
                    // Non-sticky trap skips the faulting instruction on its single cycle.
                    PCWrite    = !TRAP_STICKY;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] Op = '0;
    logic [6:0] Funct7 = '0;
    logic [2:0] Funct3 = '0;
    logic       Zero = 1'b0;
    logic       mem_ack = 1'b0;
    logic       mem_req, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrc;
    logic [5:0] EXTOp;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic [1:0] WDSel;
    logic [2:0] DMType;
    logic       trap, trap_cause;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.MEM_TIMEOUT(16), .TRAP_STICKY(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .Op         (Op),
        .Funct7     (Funct7),
        .Funct3     (Funct3),
        .Zero       (Zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .ALUSrc     (ALUSrc),
        .EXTOp      (EXTOp),
        .ALUOp      (ALUOp),
        .NPCOp      (NPCOp),
        .WDSel      (WDSel),
        .DMType     (DMType),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    // {mem_req, MemWrite, IRWrite, PCWrite, RegWrite}
    wire [4:0]  strb = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite};
    wire [26:0] outs = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrc, EXTOp,
                        ALUOp, NPCOp, WDSel, DMType, trap, trap_cause};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs 1ns after the edge, sample the strobes 1ns later.
    task automatic cyc(input string tag, input logic ack, input logic z, input logic [31:0] exp_strb);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        mem_ack = ack;
        Zero    = z;
        #1;
        check_eq(tag, 32'(strb), exp_strb);
    endtask

    // FETCH cycle with immediate ack; the new instruction bits appear with it.
    task automatic fetch(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        Op      = op;
        Funct3  = f3;
        Funct7  = f7;
        mem_ack = 1'b1;
        Zero    = 1'b0;
        #1;
        check_eq(tag, 32'(strb), 'b10100);
    endtask

    // Reset cycle with ack high: nothing at all may be driven.
    task automatic rst_cyc(input string tag);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        mem_ack = 1'b1;
        #1;
        check_eq(tag, 32'(outs), 0);
    endtask

    initial begin
        rst_cyc("reset0");
        rst_cyc("reset1");

        // add: F,D,E,WB
        fetch("add F", 7'b0110011, 3'b000, 7'b0000000);
        check_eq("add F outs", 32'(outs), 'h5000000);
        cyc("add D", 1'b0, 1'b0, 'b00000);
        check_eq("add D aluop", 32'(ALUOp), 1);
        check_eq("add D alusrc", 32'(ALUSrc), 0);
        cyc("add E", 1'b0, 1'b0, 'b00000);
        cyc("add WB", 1'b0, 1'b0, 'b00011);
        check_eq("add WB npc", 32'(NPCOp), 'b000);
        check_eq("add WB wdsel", 32'(WDSel), 'b00);

        // lbu with 3 data wait cycles: 8 cycles total
        fetch("lbu F", 7'b0000011, 3'b100, 7'b0000000);
        cyc("lbu D", 1'b0, 1'b0, 'b00000);
        check_eq("lbu D dmtype", 32'(DMType), 'b101);
        check_eq("lbu D wdsel", 32'(WDSel), 'b01);
        check_eq("lbu D extop", 32'(EXTOp), 'b010000);
        check_eq("lbu D alusrc", 32'(ALUSrc), 1);
        cyc("lbu E", 1'b0, 1'b0, 'b00000);
        for (int i = 0; i < 3; i++) cyc("lbu M wait", 1'b0, 1'b0, 'b10000);
        cyc("lbu M ack", 1'b1, 1'b0, 'b10000);
        cyc("lbu WB", 1'b0, 1'b0, 'b00011);
        check_eq("lbu WB wdsel", 32'(WDSel), 'b01);
        check_eq("lbu WB dmtype", 32'(DMType), 'b101);
        cyc("lbu next F", 1'b0, 1'b0, 'b10000);
        check_eq("lbu next F outs", 32'(outs), 'h4000000);

        // bge taken on Zero=1
        fetch("bge F", 7'b1100011, 3'b101, 7'b0000000);
        cyc("bge D", 1'b0, 1'b0, 'b00000);
        check_eq("bge D extop", 32'(EXTOp), 'b000100);
        check_eq("bge D aluop", 32'(ALUOp), 4);
        cyc("bge E", 1'b0, 1'b1, 'b00010);
        check_eq("bge E npc", 32'(NPCOp), 'b001);

        // bne not taken on Zero=1
        fetch("bne F", 7'b1100011, 3'b001, 7'b0000000);
        cyc("bne D", 1'b0, 1'b0, 'b00000);
        cyc("bne E", 1'b0, 1'b1, 'b00010);
        check_eq("bne E npc", 32'(NPCOp), 'b000);

        // bltu taken on Zero=0
        fetch("bltu F", 7'b1100011, 3'b110, 7'b0000000);
        cyc("bltu D", 1'b0, 1'b0, 'b00000);
        check_eq("bltu D aluop", 32'(ALUOp), 5);
        cyc("bltu E", 1'b0, 1'b0, 'b00010);
        check_eq("bltu E npc", 32'(NPCOp), 'b001);

        // sw with one wait cycle
        fetch("sw F", 7'b0100011, 3'b010, 7'b0000000);
        cyc("sw D", 1'b0, 1'b0, 'b00000);
        check_eq("sw D extop", 32'(EXTOp), 'b001000);
        check_eq("sw D dmtype", 32'(DMType), 'b100);
        check_eq("sw D alusrc", 32'(ALUSrc), 1);
        cyc("sw E", 1'b0, 1'b0, 'b00000);
        cyc("sw M wait", 1'b0, 1'b0, 'b11000);
        cyc("sw M ack", 1'b1, 1'b0, 'b11010);
        check_eq("sw M npc", 32'(NPCOp), 'b000);

        // jal / jalr
        fetch("jal F", 7'b1101111, 3'b000, 7'b0000000);
        cyc("jal D", 1'b0, 1'b0, 'b00000);
        cyc("jal E", 1'b0, 1'b0, 'b00000);
        cyc("jal WB", 1'b0, 1'b0, 'b00011);
        check_eq("jal WB npc", 32'(NPCOp), 'b010);
        check_eq("jal WB wdsel", 32'(WDSel), 'b10);
        fetch("jalr F", 7'b1100111, 3'b000, 7'b0000000);
        cyc("jalr D", 1'b0, 1'b0, 'b00000);
        cyc("jalr E", 1'b0, 1'b0, 'b00000);
        cyc("jalr WB", 1'b0, 1'b0, 'b00011);
        check_eq("jalr WB npc", 32'(NPCOp), 'b100);

        // Illegal opcode: sticky TRAP, cause 0
        fetch("ill F", 7'b1111111, 3'b000, 7'b0000000);
        cyc("ill D", 1'b0, 1'b0, 'b00000);
        check_eq("ill D trap", 32'(trap), 0);
        for (int i = 0; i < 4; i++) begin
            cyc("ill T strb", 1'b1, 1'b0, 'b00000);
            check_eq("ill T trap", 32'({trap, trap_cause}), 'b10);
        end
        rst_cyc("ill rst");

        // Fetch never acked: 16 request cycles, then timeout trap
        for (int i = 0; i < 16; i++) cyc("to wait", 1'b0, 1'b0, 'b10000);
        cyc("to T strb", 1'b0, 1'b0, 'b00000);
        check_eq("to T trap", 32'({trap, trap_cause}), 'b11);
        rst_cyc("to rst");

        // Ack arriving on the limit cycle wins
        for (int i = 0; i < 15; i++) cyc("lim wait", 1'b0, 1'b0, 'b10000);
        fetch("lim F", 7'b0110011, 3'b000, 7'b0100000);
        cyc("lim D", 1'b0, 1'b0, 'b00000);
        check_eq("lim D trap", 32'(trap), 0);
        check_eq("lim D aluop", 32'(ALUOp), 2);
        cyc("lim E", 1'b0, 1'b0, 'b00000);
        cyc("lim WB", 1'b0, 1'b0, 'b00011);

        // Reset while a load waits in MEM
        fetch("abort F", 7'b0000011, 3'b010, 7'b0000000);
        cyc("abort D", 1'b0, 1'b0, 'b00000);
        cyc("abort E", 1'b0, 1'b0, 'b00000);
        cyc("abort M", 1'b0, 1'b0, 'b10000);
        check_eq("abort M dmtype", 32'(DMType), 'b100);
        rst_cyc("abort rst0");
        rst_cyc("abort rst1");
        cyc("abort refetch", 1'b0, 1'b0, 'b10000);
        check_eq("abort refetch outs", 32'(outs), 'h4000000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
